// File: rtl/toycpu_regfile.sv
// toycpu_regfile: parameterised register file with two read ports, one write
// port, optional write-to-read bypass, optional hardwired-zero R0, a
// registered carry/zero flag pair and a handshaked register dump port.
//
// Dump FSM states:
//   state | meaning
//   IDLE  | no dump in progress, dump_valid low, waiting for dump_start
//   DUMP  | presenting register dump_idx, advancing on each accepted beat
module toycpu_regfile #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 4,
    parameter bit BYPASS  = 1'b0,
    parameter bit ZERO_R0 = 1'b0,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flag_we,
    input  logic              c_in,
    output logic              cFlag,
    output logic              zFlag,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [AW-1:0]     dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic {
        IDLE,
        DUMP
    } state_t;

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_en;
    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;

    // Writes to R0 are dropped when it is hardwired to zero.
    assign wr_en = we && !(ZERO_R0 && (waddr == '0));

    // Register storage; reset clears every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1: stored value, optional bypass, zero override for R0 last.
    always_comb begin
        rdata1 = regs[raddr1];
        if (BYPASS && we && (raddr1 == waddr)) rdata1 = wdata;
        if (ZERO_R0 && (raddr1 == '0)) rdata1 = '0;
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rdata2 = regs[raddr2];
        if (BYPASS && we && (raddr2 == waddr)) rdata2 = wdata;
        if (ZERO_R0 && (raddr2 == '0)) rdata2 = '0;
    end

    // Flags: Z is taken from wdata even when no register write happens.
    always_ff @(posedge clk) begin
        if (rst) begin
            cFlag <= 1'b0;
            zFlag <= 1'b0;
        end else if (flag_we) begin
            cFlag <= c_in;
            zFlag <= (wdata == '0);
        end
    end

    // Dump FSM state and beat index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Dump FSM next state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy       = 1'b0;
        dump_valid = 1'b0;
        dump_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                busy       = 1'b1;
                dump_valid = 1'b1;
                dump_last  = (idx_q == LAST_IDX);
                if (dump_ready) begin
                    if (dump_last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign dump_idx = idx_q;

    // Dump data is live storage with no bypass, so a stalled beat tracks writes.
    always_comb begin
        dump_data = regs[idx_q];
        if (ZERO_R0 && (idx_q == '0)) dump_data = '0;
    end

endmodule

// File: tb/tb_toycpu_regfile.sv
// Directed bench for toycpu_regfile: a plain instance (a) and a bypass +
// zero-R0 instance (b) share the same stimulus; expected values are written
// out by hand.
module tb_toycpu_regfile;

    localparam int DATA_W = 16;
    localparam int NREGS  = 4;
    localparam int AW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     raddr1, raddr2, waddr;
    logic              we, flag_we, c_in, dump_start, dump_ready;
    logic [DATA_W-1:0] wdata;

    logic [DATA_W-1:0] rd1_a, rd2_a, dd_a, rd1_b, rd2_b, dd_b;
    logic              c_a, z_a, dv_a, dl_a, busy_a;
    logic              c_b, z_b, dv_b, dl_b, busy_b;
    logic [AW-1:0]     di_a, di_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    toycpu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_a), .rdata2(rd2_a),
        .we(we), .waddr(waddr), .wdata(wdata),
        .flag_we(flag_we), .c_in(c_in), .cFlag(c_a), .zFlag(z_a),
        .dump_start(dump_start), .dump_valid(dv_a), .dump_ready(dump_ready),
        .dump_idx(di_a), .dump_data(dd_a), .dump_last(dl_a), .busy(busy_a)
    );

    toycpu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .flag_we(flag_we), .c_in(c_in), .cFlag(c_b), .zFlag(z_b),
        .dump_start(dump_start), .dump_valid(dv_b), .dump_ready(dump_ready),
        .dump_idx(di_b), .dump_data(dd_b), .dump_last(dl_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check one dump beat on instance a.
    task automatic chk_beat(input string tag, input logic [AW-1:0] idx,
                            input logic [DATA_W-1:0] data, input logic last);
        chk({tag, " valid"}, 32'(dv_a), 32'd1);
        chk({tag, " busy"},  32'(busy_a), 32'd1);
        chk({tag, " idx"},   32'(di_a), 32'(idx));
        chk({tag, " data"},  32'(dd_a), 32'(data));
        chk({tag, " last"},  32'(dl_a), 32'(last));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0;
        we = 1'b0; flag_we = 1'b0; c_in = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset rdata1",    32'(rd1_a), 32'h0);
        chk("reset cFlag",     32'(c_a), 32'h0);
        chk("reset zFlag",     32'(z_a), 32'h0);
        chk("reset busy",      32'(busy_a), 32'h0);
        chk("reset dump_valid",32'(dv_a), 32'h0);
        chk("reset dump_last", 32'(dl_a), 32'h0);
        chk("reset dump_idx",  32'(di_a), 32'h0);

        // Write R1 / R2, no bypass on a, bypass on b
        raddr1 = 2'd1; raddr2 = 2'd2;
        we = 1'b1; waddr = 2'd1; wdata = 16'h000A;
        #1;
        chk("R1 pre-write a", 32'(rd1_a), 32'h0);
        chk("R1 bypass b",    32'(rd1_b), 32'h000A);
        tick(); we = 1'b0; #1;
        chk("R1 post-write a", 32'(rd1_a), 32'h000A);
        chk("R2 pre-write a",  32'(rd2_a), 32'h0);
        we = 1'b1; waddr = 2'd2; wdata = 16'h000C;
        #1;
        chk("R2 bypass b", 32'(rd2_b), 32'h000C);
        tick(); we = 1'b0; #1;
        chk("R2 post-write a", 32'(rd2_a), 32'h000C);

        // R3 bypass versus registered read
        raddr1 = 2'd3;
        we = 1'b1; waddr = 2'd3; wdata = 16'h1234;
        #1;
        chk("R3 same-cycle a", 32'(rd1_a), 32'h0);
        chk("R3 same-cycle b", 32'(rd1_b), 32'h1234);
        tick(); we = 1'b0; #1;
        chk("R3 next-cycle a", 32'(rd1_a), 32'h1234);

        // Hardwired R0 on b: no bypass, no store
        raddr1 = 2'd0;
        we = 1'b1; waddr = 2'd0; wdata = 16'hFFFF;
        #1;
        chk("R0 write same-cycle b", 32'(rd1_b), 32'h0);
        tick(); we = 1'b0; #1;
        chk("R0 after write a", 32'(rd1_a), 32'hFFFF);
        chk("R0 after write b", 32'(rd1_b), 32'h0);

        // Flags
        flag_we = 1'b1; c_in = 1'b1; wdata = 16'h0000;
        tick(); #1;
        chk("flags set c", 32'(c_a), 32'h1);
        chk("flags set z", 32'(z_a), 32'h1);
        c_in = 1'b0; wdata = 16'h0005;
        tick(); #1;
        chk("flags clr c", 32'(c_a), 32'h0);
        chk("flags clr z", 32'(z_a), 32'h0);
        flag_we = 1'b0; c_in = 1'b1; wdata = 16'h0000;
        tick(); #1;
        chk("flags hold0 c", 32'(c_b), 32'h0);
        chk("flags hold0 z", 32'(z_b), 32'h0);
        flag_we = 1'b1; c_in = 1'b1; wdata = 16'h0000;
        tick();
        flag_we = 1'b0; c_in = 1'b0; wdata = 16'h0007;
        tick(); #1;
        chk("flags hold1 c", 32'(c_a), 32'h1);
        chk("flags hold1 z", 32'(z_a), 32'h1);

        // Load dump contents: R0 stays 0xFFFF on a (reads 0 on b)
        wr(2'd1, 16'h0001);
        wr(2'd2, 16'h0001);
        wr(2'd3, 16'h0002);

        // Dump with ready pattern 1,0,1,1,1
        dump_start = 1'b1; dump_ready = 1'b0;
        #1;
        chk("dump idle valid", 32'(dv_a), 32'h0);
        tick();
        dump_start = 1'b0; dump_ready = 1'b1; #1;
        chk_beat("beat0", 2'd0, 16'hFFFF, 1'b0);
        chk("beat0 data b", 32'(dd_b), 32'h0);
        tick();
        dump_ready = 1'b0; dump_start = 1'b1;
        we = 1'b1; waddr = 2'd1; wdata = 16'h0007;
        #1;
        chk_beat("beat1 stall", 2'd1, 16'h0001, 1'b0);
        tick();
        we = 1'b0; dump_start = 1'b0; dump_ready = 1'b1; #1;
        chk_beat("beat1 live", 2'd1, 16'h0007, 1'b0);
        tick(); #1;
        chk_beat("beat2", 2'd2, 16'h0001, 1'b0);
        tick();
        dump_start = 1'b1; #1;
        chk_beat("beat3", 2'd3, 16'h0002, 1'b1);
        chk("beat3 last b", 32'(dl_b), 32'h1);
        tick();
        dump_start = 1'b0; #1;
        chk("post dump busy",  32'(busy_a), 32'h0);
        chk("post dump valid", 32'(dv_a), 32'h0);
        chk("post dump last",  32'(dl_a), 32'h0);
        tick(); #1;
        chk("no second dump", 32'(busy_a), 32'h0);

        // Reset in the middle of a dump, with competing writes and flag update
        dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        tick();
        tick(); #1;
        chk("abort pre idx", 32'(di_a), 32'h2);
        rst = 1'b1; we = 1'b1; waddr = 2'd2; wdata = 16'h0009;
        flag_we = 1'b1; c_in = 1'b1; dump_start = 1'b1;
        tick();
        rst = 1'b0; we = 1'b0; flag_we = 1'b0; dump_start = 1'b0; #1;
        chk("abort valid", 32'(dv_a), 32'h0);
        chk("abort busy",  32'(busy_a), 32'h0);
        chk("abort cFlag", 32'(c_a), 32'h0);
        chk("abort zFlag", 32'(z_a), 32'h0);
        for (int i = 0; i < NREGS; i++) begin
            raddr1 = AW'(i);
            #1;
            chk($sformatf("abort R%0d", i), 32'(rd1_a), 32'h0);
        end
        dump_start = 1'b1; dump_ready = 1'b0;
        tick();
        dump_start = 1'b0; #1;
        chk("restart valid", 32'(dv_a), 32'h1);
        chk("restart idx",   32'(di_a), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/toycpu_regfile.md
# toycpu_regfile

Parametrised register file and flag unit for the next-generation toycpu datapath. It replaces the fixed four-register, 16-bit register bank with one sized by `DATA_W`/`NREGS`, with two read ports, one write port, optional same-cycle write-to-read bypass, optional hardwired-zero R0, and a registered C/Z flag pair. A handshaked dump port streams every register out in order, so benches and debug logic can read all registers without one output port per register.

## Interface

- `DATA_W`, 16: register and data width in bits.
- `NREGS`, 4: number of registers; power of two, at least 2. `AW = clog2(NREGS)`.
- `BYPASS`, 0: when 1, a read of the address being written this cycle returns `wdata` combinationally.
- `ZERO_R0`, 0: when 1, R0 always reads 0 and writes to it are discarded. This applies to the read ports and the dump port.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `raddr1`, `raddr2`  in  AW  read addresses.
- `rdata1`, `rdata2`  out  DATA_W  combinational read data.
- `we`  in  1  write enable.
- `waddr`  in  AW  write address.
- `wdata`  in  DATA_W  write data.
- `flag_we`  in  1  flag update enable.
- `c_in`  in  1  carry value to load.
- `cFlag`, `zFlag`  out  1  registered carry and zero flags.
- `dump_start`  in  1  request a full register dump.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  consumer accepts the beat.
- `dump_idx`  out  AW  index of the register in the current beat.
- `dump_data`  out  DATA_W  contents of register `dump_idx`.
- `dump_last`  out  1  high on the beat with `dump_idx == NREGS-1`.
- `busy`  out  1  high while a dump is in progress.

## Operation

- Write: when `we` is high, `wdata` is stored to `waddr` at the clock edge. With `ZERO_R0=1` and `waddr==0`, the write is discarded.
- Read: `rdata1`/`rdata2` show the current register contents. If `BYPASS=1`, `we` is high and `raddrN==waddr`, the port returns `wdata` instead; this does not apply to R0 when `ZERO_R0=1`.
- Flags: when `flag_we` is high, at the clock edge `cFlag<=c_in` and `zFlag<=(wdata==0)`. `wdata` is used for Z whether or not `we` is high. When `flag_we` is low, both flags hold.
- Dump FSM, two states: IDLE and DUMP.
  - IDLE: `busy=0`, `dump_valid=0`. `dump_start=1` moves to DUMP with `dump_idx=0`.
  - DUMP: `busy=1`, `dump_valid=1`. A beat transfers when `dump_valid && dump_ready`. On a transfer with `dump_last=0`, `dump_idx` increments. On a transfer with `dump_last=1`, the FSM returns to IDLE.
  - `dump_start` is ignored while in DUMP.
- `dump_data` is live: it always shows the current stored value of `dump_idx`, with no bypass applied. A write to that register while the beat is stalled changes `dump_data` on the next cycle. `dump_idx` stays stable until its beat is accepted.
- Read and write ports work independently of the dump. Dumping never blocks or delays writes.
- Reset: all registers 0, `cFlag=0`, `zFlag=0`, FSM in IDLE, `dump_idx=0`, `dump_valid=0`, `dump_last=0`, `busy=0`. Reset during a dump aborts it; no further beats are presented.
- Simultaneous `rst` and `we`/`flag_we`/`dump_start`: reset wins.

## Timing

- Write-to-read latency: 1 cycle with `BYPASS=0`; 0 cycles with `BYPASS=1`.
- Flag latency: 1 cycle after `flag_we`.
- Dump start: `dump_start` sampled at edge N gives `dump_valid=1`, `dump_idx=0` after edge N.
- Throughput: with `dump_ready` held high, one beat per cycle. A full dump takes exactly `NREGS` cycles, and `busy` falls on the edge that accepts the last beat.
- `dump_start` asserted on the same edge the last beat is accepted is ignored. A new dump needs `dump_start` while in IDLE.
- Minimum gap between dumps: 1 IDLE cycle.

## Test plan

- Reset, then write R1=0x000A and R2=0x000C with `BYPASS=0` → `rdata1(raddr1=1)=0x000A` and `rdata2(raddr2=2)=0x000C` one cycle after each write; before each write the port reads 0x0000.
- `BYPASS=1`: write R3=0x1234 while `raddr1=3` → `rdata1=0x1234` in the same cycle. With `BYPASS=0` the same stimulus gives 0x0000 that cycle and 0x1234 the next.
- `ZERO_R0=1`: write R0=0xFFFF, then read R0 → 0x0000; the dump beat for idx 0 also shows 0x0000.
- Flags: `flag_we=1`, `c_in=1`, `wdata=0x0000` → next cycle `cFlag=1`, `zFlag=1`. Then `flag_we=1`, `c_in=0`, `wdata=0x0005` → `cFlag=0`, `zFlag=0`. Then `flag_we=0` with any `wdata` → flags unchanged.
- Dump with registers 0x0000/0x0001/0x0001/0x0002 (`NREGS=4`), `dump_ready` toggled 1,0,1,1,1 → beats idx 0,1,2,3 with matching data; `dump_last` high only on idx 3; `busy` low after the last accept. A `dump_start` pulse during the dump causes no second dump.
- Reset asserted after the idx 1 beat is accepted → next cycle `dump_valid=0`, `busy=0`, all registers 0x0000; a fresh `dump_start` restarts at idx 0.
